ddr3_lite_model: RTL and testbench

- Synthesizable, simplified x16 DDR3 SDRAM device model for simulation of the DRAM PHY/controller path.
- Replaces the vendor DDR3 model and the GSR/PUR global-init primitives on the memory side of the SoC bench.
- Decodes DDR3 commands each clk rising edge and holds mode registers, per-bank open rows and a small backing store.
- Double-data-rate DQ is flattened to two 16-bit beats per clk, so the block uses one clock domain.

---
 rtl/ddr3_lite_pkg.sv | 62 ++++++
 rtl/ddr3_lite_delay_line.sv | 62 ++++++
 rtl/ddr3_lite_model.sv | 149 ++++++++++++++
 tb/tb_ddr3_lite_model.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ddr3_lite_pkg.sv
// Shared types and helpers for the simplified x16 DDR3 device model.
// Command encodings, token layout, CL/CWL decode and burst column order.
package ddr3_lite_pkg;

    localparam int ROW_W    = 14;
    localparam int COL_W    = 10;
    localparam int BA_W     = 3;
    localparam int DL_DEPTH = 16;
    localparam int AP_BIT   = 10;

    // {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQC = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    // One queued burst; latency is frozen when the command issues.
    typedef struct packed {
        logic             valid;
        logic             is_read;
        logic [3:0]       lat;
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } token_t;

    // code = MR0 {a6, a5, a4, a2}
    function automatic logic [3:0] cl_decode(input logic [3:0] code);
        case (code)
            4'b0010: return 4'd5;
            4'b0100: return 4'd6;
            4'b0110: return 4'd7;
            4'b1000: return 4'd8;
            4'b1010: return 4'd9;
            4'b1100: return 4'd10;
            4'b1110: return 4'd11;
            default: return 4'd5;
        endcase
    endfunction

    // f = MR2 a[5:3]
    function automatic logic [3:0] cwl_decode(input logic [2:0] f);
        logic [3:0] s;
        s = 4'd5 + {1'b0, f};
        return (s > 4'd12) ? 4'd12 : s;
    endfunction

    // Sequential burst order wraps inside the aligned 8-column block.
    function automatic logic [COL_W-1:0] beat_col(
        input logic [COL_W-1:0] col,
        input logic [2:0]       n
    );
        return {col[COL_W-1:3], col[2:0] + n};
    endfunction

endpackage

// File: rtl/ddr3_lite_delay_line.sv
// Burst token shift register with per-token latency taps.
// Ports: clk, rst, tok_i (new token), wr_*/rd_* (active burst, beat pair index).
module ddr3_lite_delay_line
    import ddr3_lite_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  token_t     tok_i,
    output logic       wr_hit_o,
    output token_t     wr_tok_o,
    output logic [1:0] wr_beat_o,
    output logic       rd_hit_o,
    output token_t     rd_tok_o,
    output logic [1:0] rd_beat_o
);

    token_t sr_q [DL_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DL_DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= tok_i;
            for (int i = 1; i < DL_DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    // A token issued at edge T sits in stage j just before edge T+j+1.
    // Write beat pair k is captured at edge T+lat+k  -> j+1 = lat+k.
    // Read beat pair k is registered at T+lat+k-1     -> j+2 = lat+k.
    logic [4:0] lat5, ow, orr;

    always_comb begin
        wr_hit_o  = 1'b0;
        wr_tok_o  = '0;
        wr_beat_o = '0;
        rd_hit_o  = 1'b0;
        rd_tok_o  = '0;
        rd_beat_o = '0;
        lat5      = '0;
        ow        = '0;
        orr       = '0;
        for (int j = 0; j < DL_DEPTH; j++) begin
            lat5 = {1'b0, sr_q[j].lat};
            ow   = 5'(j + 1) - lat5;
            orr  = 5'(j + 2) - lat5;
            if (sr_q[j].valid && !sr_q[j].is_read &&
                5'(j + 1) >= lat5 && ow < 5'd4) begin
                wr_hit_o  = 1'b1;
                wr_tok_o  = sr_q[j];
                wr_beat_o = ow[1:0];
            end
            if (sr_q[j].valid && sr_q[j].is_read &&
                5'(j + 2) >= lat5 && orr < 5'd4) begin
                rd_hit_o  = 1'b1;
                rd_tok_o  = sr_q[j];
                rd_beat_o = orr[1:0];
            end
        end
    end

endmodule

// File: rtl/ddr3_lite_model.sv
// Simplified x16 DDR3 device: command decode, mode regs, bank rows, store.
// Ports: clk/rst, cke/cs_n/ras_n/cas_n/we_n/ba/a/odt command, dq_i/dm_i in, dq_o/dq_oe/cl/cwl/err out.
module ddr3_lite_model
    import ddr3_lite_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 12,
    parameter int ROW_BITS      = 14,
    parameter int COL_BITS      = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cke,
    input  logic                cs_n,
    input  logic                ras_n,
    input  logic                cas_n,
    input  logic                we_n,
    input  logic [2:0]          ba,
    input  logic [ROW_BITS-1:0] a,
    input  logic                odt,
    input  logic [31:0]         dq_i,
    input  logic [3:0]          dm_i,
    output logic [31:0]         dq_o,
    output logic                dq_oe,
    output logic [3:0]          cl,
    output logic [3:0]          cwl,
    output logic                err
);

    logic [3:0][ROW_BITS-1:0] mr_q, mr_d;
    logic [7:0][ROW_BITS-1:0] row_q, row_d;
    logic [7:0]               open_q, open_d;
    logic                     err_q, err_d;
    logic                     oe_q, oe_d;
    logic [31:0]              dq_q, dq_d;
    logic [15:0]              mem_q [2**MEM_ADDR_BITS];

    cmd_e   cmd;
    logic   cmd_vld;
    token_t tok_d, wr_tok, rd_tok;
    logic   wr_hit, rd_hit;
    logic [1:0] wr_beat, rd_beat;
    logic [MEM_ADDR_BITS-1:0] wa0, wa1, ra0, ra1;

    assign cmd     = cmd_e'({ras_n, cas_n, we_n});
    assign cmd_vld = cke && !cs_n;
    assign cl      = cl_decode({mr_q[0][6:4], mr_q[0][2]});
    assign cwl     = cwl_decode(mr_q[2][5:3]);

    always_comb begin
        mr_d   = mr_q;
        row_d  = row_q;
        open_d = open_q;
        err_d  = 1'b0;
        tok_d  = '0;
        if (cmd_vld) begin
            unique case (cmd)
                CMD_MRS: mr_d[ba[1:0]] = a;
                CMD_PRE: begin
                    if (a[AP_BIT]) open_d = '0;
                    else           open_d[ba] = 1'b0;
                end
                CMD_ACT: begin
                    err_d      = open_q[ba];
                    open_d[ba] = 1'b1;
                    row_d[ba]  = a;
                end
                CMD_WR, CMD_RD: begin
                    if (!open_q[ba]) begin
                        err_d = 1'b1;
                    end else begin
                        tok_d.valid   = 1'b1;
                        tok_d.is_read = (cmd == CMD_RD);
                        tok_d.lat     = (cmd == CMD_RD) ? cl : cwl;
                        tok_d.ba      = ba;
                        tok_d.row     = row_q[ba];
                        tok_d.col     = a[COL_BITS-1:0];
                        if (a[AP_BIT]) open_d[ba] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    ddr3_lite_delay_line u_dl (
        .clk       (clk),
        .rst       (rst),
        .tok_i     (tok_d),
        .wr_hit_o  (wr_hit),
        .wr_tok_o  (wr_tok),
        .wr_beat_o (wr_beat),
        .rd_hit_o  (rd_hit),
        .rd_tok_o  (rd_tok),
        .rd_beat_o (rd_beat)
    );

    assign wa0 = MEM_ADDR_BITS'({wr_tok.ba, wr_tok.row,
                 beat_col(wr_tok.col, {wr_beat, 1'b0})});
    assign wa1 = MEM_ADDR_BITS'({wr_tok.ba, wr_tok.row,
                 beat_col(wr_tok.col, {wr_beat, 1'b1})});
    assign ra0 = MEM_ADDR_BITS'({rd_tok.ba, rd_tok.row,
                 beat_col(rd_tok.col, {rd_beat, 1'b0})});
    assign ra1 = MEM_ADDR_BITS'({rd_tok.ba, rd_tok.row,
                 beat_col(rd_tok.col, {rd_beat, 1'b1})});

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            if (!dm_i[0]) mem_q[wa0][7:0]  <= dq_i[7:0];
            if (!dm_i[1]) mem_q[wa0][15:8] <= dq_i[15:8];
            if (!dm_i[2]) mem_q[wa1][7:0]  <= dq_i[23:16];
            if (!dm_i[3]) mem_q[wa1][15:8] <= dq_i[31:24];
        end
    end

    // Same-edge write is not visible here, so a colliding read sees old data.
    assign oe_d = rd_hit;
    assign dq_d = rd_hit ? {mem_q[ra1], mem_q[ra0]} : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mr_q   <= '0;
            row_q  <= '0;
            open_q <= '0;
            err_q  <= 1'b0;
            oe_q   <= 1'b0;
            dq_q   <= '0;
        end else begin
            mr_q   <= mr_d;
            row_q  <= row_d;
            open_q <= open_d;
            err_q  <= err_d;
            oe_q   <= oe_d;
            dq_q   <= dq_d;
        end
    end

    assign dq_o  = dq_q;
    assign dq_oe = oe_q;
    assign err   = err_q;

    logic unused_ok;
    assign unused_ok = ^{odt, mr_q[1], mr_q[3],
                         mr_q[0][ROW_BITS-1:7], mr_q[0][3], mr_q[0][1:0],
                         mr_q[2][ROW_BITS-1:6], mr_q[2][2:0],
                         wr_tok.valid, wr_tok.is_read, wr_tok.lat,
                         rd_tok.valid, rd_tok.is_read, rd_tok.lat};

endmodule

// File: tb/tb_ddr3_lite_model.sv
// Directed cycle-table bench for ddr3_lite_model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ddr3_lite_model;

    localparam int NV = 75;
    localparam logic [2:0] MRS = 3'b000;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] RD  = 3'b101;

    typedef struct {
        logic        cke;
        logic        cs_n;
        logic [2:0]  cmd;
        logic [2:0]  ba;
        logic [13:0] a;
        logic [31:0] dq;
        logic [3:0]  dm;
        logic        e_oe;
        logic [31:0] e_dq;
        logic        e_err;
        logic [3:0]  e_cl;
    } vec_t;

    vec_t tv [NV];
    int nchk = 0;
    int nerr = 0;

    logic        clk, rst, cke, cs_n, ras_n, cas_n, we_n, odt;
    logic [2:0]  ba;
    logic [13:0] a;
    logic [31:0] dq_i, dq_o;
    logic [3:0]  dm_i, cl, cwl;
    logic        dq_oe, err;

    ddr3_lite_model dut (
        .clk   (clk),
        .rst   (rst),
        .cke   (cke),
        .cs_n  (cs_n),
        .ras_n (ras_n),
        .cas_n (cas_n),
        .we_n  (we_n),
        .ba    (ba),
        .a     (a),
        .odt   (odt),
        .dq_i  (dq_i),
        .dm_i  (dm_i),
        .dq_o  (dq_o),
        .dq_oe (dq_oe),
        .cl    (cl),
        .cwl   (cwl),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %h, want %h",
                     name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic oe,
                              input logic [31:0] d, input logic e,
                              input logic [3:0] c);
        check("dq_oe", idx, {31'd0, dq_oe}, {31'd0, oe});
        check("dq_o",  idx, dq_o, d);
        check("err",   idx, {31'd0, err}, {31'd0, e});
        check("cl",    idx, {28'd0, cl}, {28'd0, c});
        check("cwl",   idx, {28'd0, cwl}, 32'd5);
    endtask

    task automatic put_cmd(input int i, input logic [2:0] c,
                           input logic [2:0] b, input logic [13:0] ad);
        tv[i].cs_n = 1'b0;
        tv[i].cmd  = c;
        tv[i].ba   = b;
        tv[i].a    = ad;
    endtask

    task automatic put_wd(input int i, input logic [31:0] d,
                          input logic [3:0] m);
        tv[i].dq = d;
        tv[i].dm = m;
    endtask

    task automatic put_rd(input int i, input logic [31:0] d);
        tv[i].e_oe = 1'b1;
        tv[i].e_dq = d;
    endtask

    initial begin
        for (int i = 0; i < NV; i++) begin
            tv[i] = '{cke: 1'b1, cs_n: 1'b1, cmd: 3'b111, ba: 3'd0,
                      a: 14'd0, dq: 32'd0, dm: 4'hF, e_oe: 1'b0,
                      e_dq: 32'd0, e_err: 1'b0, e_cl: 4'd6};
        end
        tv[0].e_cl = 4'd5;
        tv[1].e_cl = 4'd5;
        put_cmd(0, MRS, 3'd2, 14'h200);
        put_cmd(1, MRS, 3'd0, 14'h320);
        put_cmd(2, ACT, 3'd0, 14'h000);
        put_cmd(3, WR,  3'd0, 14'h000);
        put_wd(8,  32'h12345678, 4'h0);
        put_wd(9,  32'h0000AAAA, 4'h0);
        put_wd(10, 32'h0000BBBB, 4'h0);
        put_wd(11, 32'h0000CCCC, 4'h0);
        put_cmd(12, RD, 3'd0, 14'h000);
        put_rd(18, 32'h12345678);
        put_rd(19, 32'h0000AAAA);
        put_rd(20, 32'h0000BBBB);
        put_rd(21, 32'h0000CCCC);
        put_cmd(22, RD, 3'd0, 14'h002);
        put_rd(28, 32'h0000AAAA);
        put_rd(29, 32'h0000BBBB);
        put_rd(30, 32'h0000CCCC);
        put_rd(31, 32'h12345678);
        put_cmd(32, WR, 3'd0, 14'h000);
        put_wd(37, 32'h9999EEEE, 4'b0010);
        put_wd(38, 32'h11112222, 4'h0);
        put_wd(39, 32'hFFFFFFFF, 4'hF);
        put_wd(40, 32'hFFFFFFFF, 4'hF);
        put_cmd(41, RD, 3'd0, 14'h000);
        put_rd(47, 32'h999956EE);
        put_rd(48, 32'h11112222);
        put_rd(49, 32'h0000BBBB);
        put_rd(50, 32'h0000CCCC);
        put_cmd(51, RD, 3'd3, 14'h000);
        tv[52].e_err = 1'b1;
        put_cmd(53, RD, 3'd3, 14'h000);
        tv[53].cke = 1'b0;
        put_cmd(55, ACT, 3'd0, 14'h000);
        tv[56].e_err = 1'b1;
        put_cmd(57, RD, 3'd0, 14'h400);
        put_rd(63, 32'h999956EE);
        put_rd(64, 32'h11112222);
        put_rd(65, 32'h0000BBBB);
        put_rd(66, 32'h0000CCCC);
        put_cmd(58, RD, 3'd0, 14'h000);
        tv[59].e_err = 1'b1;
        put_cmd(67, ACT, 3'd0, 14'h000);
        put_cmd(68, RD, 3'd0, 14'h000);
        put_rd(74, 32'h999956EE);

        rst = 1'b1;
        cke = 1'b1;
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        ba = '0;
        a = '0;
        odt = 1'b0;
        dq_i = '0;
        dm_i = 4'hF;
        repeat (3) @(negedge clk);
        check_outs(-1, 1'b0, 32'd0, 1'b0, 4'd5);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check_outs(i, tv[i].e_oe, tv[i].e_dq, tv[i].e_err, tv[i].e_cl);
            cke  = tv[i].cke;
            cs_n = tv[i].cs_n;
            {ras_n, cas_n, we_n} = tv[i].cmd;
            ba   = tv[i].ba;
            a    = tv[i].a;
            dq_i = tv[i].dq;
            dm_i = tv[i].dm;
        end

        // Reset lands in the second cycle of the last read burst.
        @(negedge clk);
        check("dq_oe", 75, {31'd0, dq_oe}, 32'd1);
        check("dq_o",  75, dq_o, 32'h11112222);
        rst = 1'b1;
        @(negedge clk);
        check_outs(76, 1'b0, 32'd0, 1'b0, 4'd5);
        rst = 1'b0;
        for (int i = 77; i < 80; i++) begin
            @(negedge clk);
            check_outs(i, 1'b0, 32'd0, 1'b0, 4'd5);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
